// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, stall, flush and halt-drain controller for the 5-stage RV32I pipeline
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_halt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             wb_retire,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, flush_q, retire_q;

  logic       stall_inc, flush_inc, retire_inc;
  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used, load_use;

  // Only opcode and register-source fields matter for hazard detection
  logic unused_instr_bits;
  assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:7]};

  assign opc = if_id_instr[6:0];
  assign rs1 = if_id_instr[19:15];
  assign rs2 = if_id_instr[24:20];

  // Decode which source fields are real reads and detect the load-use hazard
  always_comb begin
    rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((rs1_used && (rs1 == id_ex_rd)) || (rs2_used && (rs2 == id_ex_rd)));
  end

  // Next-state and pipeline control; a bubble holds PC and IF/ID while ID/EX loads zeros
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            stall_inc = 1'b1;
          end else if (id_ex_halt) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            state_d     = ST_DRAIN;
            drain_d     = DRAIN_INIT;
          end else if (ex_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (mem_busy) begin
            stall_inc = 1'b1;
          end else begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if (drain_q == '0) begin
              state_d = ST_HALTED;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign retire_inc = wb_retire && mem_wb_en;

  // State, drain counter, halt flag and saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
      if (retire_inc && (retire_q != '1)) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign halted     = halted_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign retire_cnt = retire_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard/stall/flush controller for the 5-stage RV32I core.
- Consumes fields of the IF/ID, ID/EX and MEM/WB buffer registers and the EX-stage redirect.
- Drives the enable/flush controls that write those registers and the PC.
- Owns load-use bubbling, branch/jump flushing, memory-busy freeze, halt drain, and performance counters.

Parameters:
DRAIN_CYCLES, 3, cycles after halt detection in ID/EX before the core freezes (EX, MEM, WB retire)
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-low; reset=0 at a rising clk edge resets all state
if_id_instr  input  32  Curr_Instr held in IF/ID
id_ex_mem_read  input  1  MemRead of ID/EX
id_ex_rd  input  5  rd of ID/EX
id_ex_halt  input  1  Halt of ID/EX
ex_redirect  input  1  EX resolved taken branch/jal/jalr, PC must be redirected
mem_busy  input  1  data memory not ready, whole pipeline must hold
wb_retire  input  1  MEM/WB holds a valid instruction retiring this cycle
pc_en  output  1  PC register write enable
if_id_en  output  1  IF/ID write enable
if_id_flush  output  1  IF/ID load bubble (all zero)
id_ex_en  output  1  ID/EX write enable
id_ex_flush  output  1  ID/EX load bubble
ex_mem_en  output  1  EX/MEM write enable
mem_wb_en  output  1  MEM/WB write enable
halted  output  1  core stopped
stall_cnt  output  CNT_W  stall cycles
flush_cnt  output  CNT_W  redirect flushes
retire_cnt  output  CNT_W  retired instructions

Behaviour:
- Control outputs are combinational from state and current inputs and act in the same cycle. State, counter and halted outputs are registered.
- While reset=0: all enables 0, all flushes 0, halted 0, counters 0. State is RUN and the drain counter is 0.
- rs1=if_id_instr[19:15], rs2=if_id_instr[24:20], opc=if_id_instr[6:0].
  - rs1 is used unless opc is 0110111, 0010111 or 1101111.
  - rs2 is used only for opc 0110011, 0100011 or 1100011.
- load_use = id_ex_mem_read && id_ex_rd!=0 && ((rs1 used && rs1==id_ex_rd) || (rs2 used && rs2==id_ex_rd)).
- States: RUN, DRAIN, HALTED.
- RUN priority, highest first:
  1. mem_busy: freeze. All enables 0, flushes 0. Requests are deferred because their sources are frozen.
  2. id_ex_halt: go to DRAIN with drain counter = DRAIN_CYCLES-1. This cycle: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. The halt instruction advances to EX.
  3. ex_redirect: if_id_flush=1, id_ex_flush=1, all enables 1. Wins over load_use because the dependent instruction is wrong-path.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. One bubble. On the next cycle the bubble clears load_use.
  5. Otherwise: all enables 1, flushes 0.
- DRAIN:
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. ex_redirect and load_use are ignored.
  - mem_busy=1 freezes everything, and the counter holds.
  - Otherwise the counter decrements. When it is 0 on a non-busy cycle, go to HALTED next edge.
- HALTED:
  - All enables 0, flushes 0, halted=1 (registered, set on entry edge). All inputs are ignored.
  - Exit only via reset.
- Counters saturate at all ones and never wrap.
  - stall_cnt +1 on each cycle with (RUN && mem_busy) or (DRAIN && mem_busy) or the RUN load_use bubble.
  - flush_cnt +1 per applied redirect (item 3).
  - retire_cnt +1 when wb_retire && mem_wb_en.
- Reset mid-DRAIN or mid-stall returns to RUN with counters cleared on the same edge.

Test Plan:
- Load x5, then "add x6,x5,x7" in IF/ID (id_ex_mem_read=1, id_ex_rd=5) -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle all enables 1. stall_cnt=1.
- Same load followed by "lui x5,…" (rs1 field equals 5) and by "addi x6,x0,1" with id_ex_rd=0 -> no stall in either case. stall_cnt stays 0.
- ex_redirect=1 with load_use=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt=1, stall_cnt=0.
- id_ex_halt=1 with DRAIN_CYCLES=3 -> DRAIN for 3 cycles. halted=1 on the 4th edge; afterwards all enables 0. Pulses of ex_redirect in HALTED are ignored.
- mem_busy held 2 cycles during DRAIN -> all enables 0 during those cycles. HALTED entry is delayed by exactly 2 cycles. stall_cnt +2.
- Preload retire_cnt near saturation (2^CNT_W-2) using wb_retire=1 for 3 cycles -> saturates at 2^CNT_W-1. Reset=0 for one edge mid-DRAIN -> state RUN, counters 0, halted 0.
